// File: rtl/dffram_arb_pkg.sv
// Shared types for the two-port DFFRAM arbiter: the arbitration state
// encoding and the port identifier.
package dffram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/dffram_arb_rr.sv
// Two-way request picker producing a one-hot grant. On a tie it picks either
// the port that was not the last owner, or port 0 when FIXED_PRIO is set.
module dffram_arb_rr
  import dffram_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  port_id_t   last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (FIXED_PRIO != 0) begin
        gnt = 2'b01;
      end else if (last_owner == PORT0) begin
        gnt = 2'b10;
      end else begin
        gnt = 2'b01;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dffram_arbiter.sv
// Arbitrates two request/grant ports onto one external single-port DFFRAM.
// State | meaning: IDLE | no grant last cycle; OWN0/OWN1 | that port was granted last cycle.
module dffram_arbiter
  import dffram_arb_pkg::*;
#(
  parameter  int COLS       = 1,
  parameter  int FIXED_PRIO = 0,
  localparam int A_WIDTH    = 8 + $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               p0_req,
  input  logic               p0_lock,
  input  logic [3:0]         p0_we,
  input  logic [A_WIDTH-1:0] p0_addr,
  input  logic [31:0]        p0_wdata,
  output logic               p0_gnt,
  output logic               p0_rvalid,
  output logic [31:0]        p0_rdata,
  input  logic               p1_req,
  input  logic               p1_lock,
  input  logic [3:0]         p1_we,
  input  logic [A_WIDTH-1:0] p1_addr,
  input  logic [31:0]        p1_wdata,
  output logic               p1_gnt,
  output logic               p1_rvalid,
  output logic [31:0]        p1_rdata,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [A_WIDTH-1:0] ram_a,
  output logic [31:0]        ram_di,
  input  logic [31:0]        ram_do
);

  arb_state_t state_q, state_d;
  port_id_t   last_q, last_d;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic       rv0_q, rv1_q;

  dffram_arb_rr #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
    .req        ({p1_req, p0_req}),
    .last_owner (last_q),
    .gnt        (pick)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      last_q  <= PORT1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Lock overrides the picker only while the locked port still owns the RAM;
  // grants are gated by reset so nothing reaches the RAM while held in reset.
  always_comb begin
    gnt     = pick;
    state_d = IDLE;
    last_d  = last_q;
    if (state_q == OWN0 && p0_lock && p0_req) begin
      gnt = 2'b01;
    end else if (state_q == OWN1 && p1_lock && p1_req) begin
      gnt = 2'b10;
    end
    gnt = gnt & {2{RESETn}};
    if (gnt[0]) begin
      state_d = OWN0;
      last_d  = PORT0;
    end else if (gnt[1]) begin
      state_d = OWN1;
      last_d  = PORT1;
    end
  end

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];
  assign ram_en = |gnt;

  always_comb begin
    ram_we = 4'b0000;
    ram_a  = '0;
    ram_di = 32'h0;
    if (gnt[0]) begin
      ram_we = p0_we;
      ram_a  = p0_addr;
      ram_di = p0_wdata;
    end else if (gnt[1]) begin
      ram_we = p1_we;
      ram_a  = p1_addr;
      ram_di = p1_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= gnt[0];
      rv1_q <= gnt[1];
    end
  end

  assign p0_rvalid = rv0_q;
  assign p1_rvalid = rv1_q;
  assign p0_rdata  = rv0_q ? ram_do : 32'h0;
  assign p1_rdata  = rv1_q ? ram_do : 32'h0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter: round-robin instance with a RAM model,
// plus a fixed-priority instance sharing the same port stimulus.
module tb_dffram_arbiter;

  localparam int COLS = 1;
  localparam int AW   = 8 + $clog2(COLS);

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          p0_req = 0, p0_lock = 0, p1_req = 0, p1_lock = 0;
  logic [3:0]    p0_we = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = 0, p1_addr = 0;
  logic [31:0]   p0_wdata = 0, p1_wdata = 0;

  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_di;
  logic [31:0]   ram_do = 32'h0;

  logic          fp_p0_gnt, fp_p1_gnt, fp_p0_rvalid, fp_p1_rvalid;
  logic [31:0]   fp_p0_rdata, fp_p1_rdata;
  logic          fp_ram_en;
  logic [3:0]    fp_ram_we;
  logic [AW-1:0] fp_ram_a;
  logic [31:0]   fp_ram_di;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dffram_arbiter #(.COLS(COLS), .FIXED_PRIO(0)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
  );

  dffram_arbiter #(.COLS(COLS), .FIXED_PRIO(1)) dut_fp (
    .CLK(CLK), .RESETn(RESETn),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(fp_p0_gnt), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(fp_p1_gnt), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
    .ram_en(fp_ram_en), .ram_we(fp_ram_we), .ram_a(fp_ram_a), .ram_di(fp_ram_di), .ram_do(32'h0)
  );

  // Registered single-port RAM model: read-old-data, outputs 0 when idle.
  logic [31:0] mem [0:(256*COLS)-1];
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end else begin
      ram_do <= 32'h0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    p0_req = 0; p0_lock = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_lock = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clear_inputs();
    RESETn = 0;
    @(negedge CLK);
    RESETn = 1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESETn = 0;
    p0_req = 1; p1_req = 1; p0_we = 4'hF; p0_addr = 8'h55; p0_wdata = 32'hA5A5A5A5;
    #1;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {p0_gnt, p1_gnt}); end
    checks++; if ({fp_p0_gnt, fp_p1_gnt} !== 2'b00) begin failures++; $display("FAIL reset_fp_gnt got=%b exp=00", {fp_p0_gnt, fp_p1_gnt}); end
    checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
    checks++; if ({ram_we, ram_a, ram_di} !== '0) begin failures++; $display("FAIL reset_ram_bus got=%h/%h/%h exp=0", ram_we, ram_a, ram_di); end
    @(negedge CLK); #1;
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {p0_rvalid, p1_rvalid}); end
    checks++; if ({p0_rdata, p1_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {p0_rdata, p1_rdata}); end
    clear_inputs();
    RESETn = 1;
  endtask

  task automatic test_single_read();
    @(negedge CLK);
    p0_req = 1; p0_we = 4'hF; p0_addr = 8'h10; p0_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", p0_gnt); end
    checks++; if ({ram_en, ram_we, ram_a, ram_di} !== {1'b1, 4'hF, 8'h10, 32'hDEADBEEF})
      begin failures++; $display("FAIL wr_ram_bus got=%b/%h/%h/%h exp=1/f/10/deadbeef", ram_en, ram_we, ram_a, ram_di); end
    @(negedge CLK);
    p0_we = 4'h0; p0_wdata = 32'h0;
    #1;
    checks++; if ({p0_gnt, p0_rvalid, ram_we} !== {1'b1, 1'b1, 4'h0}) begin failures++; $display("FAIL rd_issue got=%b/%b/%h exp=1/1/0", p0_gnt, p0_rvalid, ram_we); end
    @(negedge CLK);
    clear_inputs();
    #1;
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b10) begin failures++; $display("FAIL rd_rvalid got=%b exp=10", {p0_rvalid, p1_rvalid}); end
    checks++; if (p0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", p0_rdata); end
    checks++; if (p1_rdata !== 32'h0) begin failures++; $display("FAIL rd_other_data got=%h exp=0", p1_rdata); end
    @(negedge CLK); #1;
    checks++; if ({p0_rvalid, p0_rdata} !== 33'h0) begin failures++; $display("FAIL rd_after got=%b/%h exp=0/0", p0_rvalid, p0_rdata); end
  endtask

  // Round-robin alternates from reset; fixed priority always picks port 0.
  task automatic test_tie();
    logic [1:0] exp_rr [4];
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        p0_req = 1; p1_req = 1; p0_addr = 8'h10; p1_addr = 8'h10;
      end
      #1;
      checks++; if ({p1_gnt, p0_gnt} !== exp_rr[c]) begin failures++; $display("FAIL rr_tie cycle=%0d got=%b exp=%b", c, {p1_gnt, p0_gnt}, exp_rr[c]); end
      checks++; if ({fp_p1_gnt, fp_p0_gnt} !== 2'b01) begin failures++; $display("FAIL fp_tie cycle=%0d got=%b exp=01", c, {fp_p1_gnt, fp_p0_gnt}); end
      if (c > 0) begin
        checks++; if ({p1_rvalid, p0_rvalid} !== exp_rr[c-1]) begin failures++; $display("FAIL b2b_rvalid cycle=%0d got=%b exp=%b", c, {p1_rvalid, p0_rvalid}, exp_rr[c-1]); end
      end
      @(negedge CLK);
    end
    clear_inputs();
    #1;
    checks++; if ({p1_rvalid, p0_rvalid, p1_rdata} !== {2'b10, 32'hDEADBEEF}) begin failures++; $display("FAIL b2b_last got=%b/%h exp=10/deadbeef", {p1_rvalid, p0_rvalid}, p1_rdata); end
  endtask

  task automatic test_lock();
    do_reset();
    p1_req = 1; p1_lock = 1;
    #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b10) begin failures++; $display("FAIL lock_c0 got=%b exp=10", {p1_gnt, p0_gnt}); end
    for (int c = 1; c < 3; c++) begin
      @(negedge CLK);
      p0_req = 1;
      #1;
      checks++; if ({p1_gnt, p0_gnt} !== 2'b10) begin failures++; $display("FAIL lock_hold cycle=%0d got=%b exp=10", c, {p1_gnt, p0_gnt}); end
    end
    @(negedge CLK);
    p1_lock = 0;
    #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b01) begin failures++; $display("FAIL lock_release got=%b exp=01", {p1_gnt, p0_gnt}); end
    @(negedge CLK);
    clear_inputs();
    @(negedge CLK);
    p0_req = 1; p1_req = 1; p0_lock = 1;
    #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b10) begin failures++; $display("FAIL lock_idle_ignored got=%b exp=10", {p1_gnt, p0_gnt}); end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_byte_write();
    @(negedge CLK);
    p1_req = 1; p1_we = 4'hF; p1_addr = 8'h20; p1_wdata = 32'h11223344;
    @(negedge CLK);
    p1_we = 4'b0010; p1_wdata = 32'h0000AB00;
    #1;
    checks++; if ({p1_gnt, ram_we, ram_di} !== {1'b1, 4'b0010, 32'h0000AB00}) begin failures++; $display("FAIL bw_bus got=%b/%b/%h exp=1/0010/0000ab00", p1_gnt, ram_we, ram_di); end
    @(negedge CLK);
    p1_we = 4'h0; p1_wdata = 32'h0;
    @(negedge CLK);
    clear_inputs();
    #1;
    checks++; if ({p1_rvalid, p1_rdata} !== {1'b1, 32'h1122AB44}) begin failures++; $display("FAIL bw_p1_read got=%b/%h exp=1/1122ab44", p1_rvalid, p1_rdata); end
    @(negedge CLK);
    p0_req = 1; p0_addr = 8'h20;
    @(negedge CLK);
    clear_inputs();
    #1;
    checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'h1122AB44}) begin failures++; $display("FAIL bw_p0_read got=%b/%h exp=1/1122ab44", p0_rvalid, p0_rdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    p0_req = 1; p0_addr = 8'h10;
    @(negedge CLK);
    clear_inputs();
    #1;
    checks++; if (p0_rvalid !== 1'b1) begin failures++; $display("FAIL mid_pre_rvalid got=%b exp=1", p0_rvalid); end
    RESETn = 0;
    p0_req = 1; p1_req = 1;
    #1;
    checks++; if ({p0_rvalid, p0_rdata, ram_en} !== {1'b0, 32'h0, 1'b0}) begin failures++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0", p0_rvalid, p0_rdata, ram_en); end
    @(negedge CLK);
    RESETn = 1;
    #1;
    checks++; if ({p1_gnt, p0_gnt} !== 2'b01) begin failures++; $display("FAIL mid_first_tie got=%b exp=01", {p1_gnt, p0_gnt}); end
    @(negedge CLK);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_lock();
    test_byte_write();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
